// File: rtl/regseq_pkg.sv
// rtl/regseq_pkg.sv - shared types and constants for the register-file sequencer
//
// Purpose : operation and FSM state encodings plus the hard-wired zero register index.
// Contents: op_t (ADD/SUB/MOV/LI), state_t (IDLE/READ/EXEC/WRITE), REG_ZERO.
package regseq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MOV = 2'b10,
    OP_LI  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - command handshake and register-file port bundle
//
// Purpose : groups the command channel and the register-file ports of the sequencer.
// Ports   : cmd_valid/cmd_ready/cmd_op/cmd_rd/cmd_rs1/cmd_rs2/cmd_imm (command),
//           ra1/ra2/rd1/rd2 (read ports), wa3/wd3/we3 (write port), busy/done (status).
// Modports: master = sequencer side, slave = command source / register-file side.
interface regfile_sequencer_if #(
  parameter int N  = 8,
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [N-1:0]  cmd_imm;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [N-1:0]  rd1;
  logic [N-1:0]  rd2;
  logic [AW-1:0] wa3;
  logic [N-1:0]  wd3;
  logic          we3;
  logic          busy;
  logic          done;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rd1, rd2,
    output cmd_ready, ra1, ra2, wa3, wd3, we3, busy, done
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rd1, rd2,
    input  cmd_ready, ra1, ra2, wa3, wd3, we3, busy, done
  );
endinterface

// File: rtl/regseq_alu.sv
// rtl/regseq_alu.sv - combinational N-bit ALU for the register-file sequencer
//
// Purpose : result = a+b (ADD), a-b (SUB), a (MOV/LI), all modulo 2^N.
// Ports   : op (operation), a/b (operands), result (N bits), carry
//           (ADD carry-out, SUB borrow a<b, 0 otherwise).
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int N = 8
) (
  input  op_t          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         carry
);

  logic [N:0] sum;

  always_comb begin
    sum    = '0;
    result = a;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[N-1:0];
        carry  = sum[N];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - serialised read/execute/write-back sequencer for an 8-entry register file
//
// Purpose : accepts one micro-op at a time and walks it through READ, EXEC and WRITE.
//           LI skips straight to WRITE. Writes to register 0 are suppressed.
// Ports   : clk, rst (async active-low), bus (regfile_sequencer_if.master),
//           flag_z/flag_c only when REGSEQ_FLAGS_EN is defined.
// Options : REGSEQ_FLAGS_EN adds zero/carry flags updated on every retirement.
module regfile_sequencer
  import regseq_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic clk,
  input  logic rst,
  regfile_sequencer_if.master bus
`ifdef REGSEQ_FLAGS_EN
  ,
  output logic flag_z,
  output logic flag_c
`endif
);

  localparam logic [AW-1:0] ZERO_ADDR = REG_ZERO[AW-1:0];

  state_t        state, state_nxt;
  op_t           op_q;
  logic [AW-1:0] rd_q;
  logic [N-1:0]  a_q, b_q;
  logic [N-1:0]  alu_result;
  logic          alu_carry;
  logic          accept;
  logic          accept_li;

  assign accept    = (state == IDLE) && bus.cmd_valid;
  assign accept_li = accept && (op_t'(bus.cmd_op) == OP_LI);

  regseq_alu #(.N(N)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) state_nxt = accept_li ? WRITE : READ;
      end
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // wd3 doubles as the result register: it is loaded on the edge that enters
  // WRITE, so we3/done/wd3 are all valid together during the WRITE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_ADD;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bus.ra1  <= '0;
      bus.ra2  <= '0;
      bus.wa3  <= '0;
      bus.wd3  <= '0;
      bus.we3  <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op_t'(bus.cmd_op);
            rd_q    <= bus.cmd_rd;
            bus.ra1 <= bus.cmd_rs1;
            bus.ra2 <= bus.cmd_rs2;
          end
          if (accept_li) begin
            bus.wa3  <= bus.cmd_rd;
            bus.wd3  <= bus.cmd_imm;
            bus.we3  <= (bus.cmd_rd != ZERO_ADDR);
            bus.done <= 1'b1;
          end
        end
        READ: begin
          a_q <= bus.rd1;
          b_q <= bus.rd2;
        end
        EXEC: begin
          bus.wa3  <= rd_q;
          bus.wd3  <= alu_result;
          bus.we3  <= (rd_q != ZERO_ADDR);
          bus.done <= 1'b1;
        end
        WRITE: begin
          bus.we3  <= 1'b0;
          bus.done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef REGSEQ_FLAGS_EN
  // Flags land on the same edge as wd3 so they are visible alongside done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (accept_li) begin
      flag_z <= (bus.cmd_imm == '0);
      flag_c <= 1'b0;
    end else if (state == EXEC) begin
      flag_z <= (alu_result == '0);
      flag_c <= alu_carry;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven controller that sequences the 8-entry register file through read, execute and write-back phases. It accepts one register-to-register micro-operation at a time over a valid/ready handshake. It drives the register file's two read-address ports and its single write port, and computes the result with an internal N-bit ALU. It sits between the instruction-decode logic and the register file in the LASD datapath.

## Interface
- N, 8, data width; matches register-file word width
- AW, 3, register address width (2^AW registers)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 ADD, 01 SUB, 10 MOV, 11 LI
- cmd_rd  in  AW  destination register
- cmd_rs1  in  AW  source 1
- cmd_rs2  in  AW  source 2 (ADD/SUB only)
- cmd_imm  in  N  immediate (LI only)
- ra1, ra2  out  AW  register-file read addresses
- rd1, rd2  in  N  register-file read data (combinational from ra1/ra2)
- wa3  out  AW  write address
- wd3  out  N  write data
- we3  out  1  write enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a command retires
- flag_z, flag_c  out  1  present only with REGSEQ_FLAGS_EN

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE: cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op/rd/rs1/rs2/imm.
  - Load ra1<=cmd_rs1 and ra2<=cmd_rs2.
  - LI goes to WRITE with result<=cmd_imm. All other ops go to READ.
- READ: capture rd1/rd2 into operand registers A/B. Go to EXEC.
- EXEC: result<=A+B (ADD), A-B (SUB), or A (MOV). Go to WRITE.
- WRITE: drive wa3=rd and wd3=result. Assert we3 unless rd==0, in which case register 0 stays zero and we3 is held low. Pulse done. Go to IDLE.
- cmd_ready is low in READ, EXEC and WRITE. Commands are strictly serialized, so there are no hazards.
- Arithmetic: all results are modulo 2^N.
  - carry = bit N of the (N+1)-bit sum for ADD.
  - For SUB, carry = borrow (A<B).
  - MOV and LI leave carry at 0.
- Outputs ra1, ra2, wa3, wd3, we3 and done are registered. Glitch-free.

## Timing
- Reset (rst low, asynchronous): state=IDLE; ra1/ra2/wa3/wd3=0; we3=0; done=0; busy=0; operand/result registers=0; flags=0.
  - cmd_ready=1 as soon as rst is released.
  - A command in flight is dropped and no write occurs.
- Latency from the accept edge (cycle 0):
  - ADD/SUB/MOV: we3 and done are high in cycle 3. The register file is updated at the end of cycle 3. Next accept is possible in cycle 4.
  - LI: we3 and done are high in cycle 1. Next accept is possible in cycle 2.
- A command presented while busy is not accepted and must be held by the source.
- rd==rs1 or rd==rs2: legal. Operands are captured in READ, before the write.
- A back-to-back command that reads the previous rd sees the new value, because the write completes before the next READ.

## Configuration
- REGSEQ_FLAGS_EN defined:
  - flag_z and flag_c exist.
  - Both update in WRITE for every op: flag_z=(result==0), flag_c as defined above.
  - They hold their value otherwise and are cleared by reset.
- REGSEQ_FLAGS_EN undefined:
  - Ports and flag logic are absent.
  - All other behaviour is identical.

## Structure
- Package regseq_pkg:
  - op_t enum (OP_ADD=2'b00, OP_SUB, OP_MOV, OP_LI).
  - state_t enum (IDLE, READ, EXEC, WRITE).
  - Constant REG_ZERO=0.
- Sub-module regseq_alu: combinational block with inputs op, A, B and outputs result[N-1:0] and carry. Instantiated once and used in EXEC.
- Top: FSM, command/operand/result registers, output registers.

## Test plan
- LI r1,0xAB -> we3=1, wa3=1, wd3=0xAB one cycle after accept; done pulses; cmd_ready returns the next cycle.
- With r1=0xAB and r2=0x56: ADD r3,r1,r2 -> cycle 3: we3=1, wa3=3, wd3=0x01, flag_c=1, flag_z=0 (flags only with REGSEQ_FLAGS_EN).
- SUB r4,r2,r1 (0x56-0xAB) -> wd3=0xAB, flag_c=1. Then SUB r5,r1,r1 -> wd3=0x00, flag_z=1, flag_c=0.
- MOV r0,r1 -> full 4-cycle sequence with we3 held low; done pulses; a later read of r0 returns 0x00.
- cmd_valid held during a busy ADD -> cmd_ready=0 and nothing is accepted until cycle 4. The waiting LI r3,0x11 executes afterward and sees no corruption.
- rst asserted during EXEC of ADD r6,r1,r2 -> outputs clear immediately, we3 never rises, and r6 is unchanged.
